// File: rtl/instr_split_buf.sv
// instr_split_buf: small FIFO that splits each incoming instruction word into
// opcode and data fields at push time and presents the head entry downstream.
// Field order is chosen per push by op_low; stored entries keep their split.
module instr_split_buf #(
    parameter int OP_W   = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    localparam int W     = OP_W + DATA_W,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_word,
    input  logic              op_low,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     count,
    output logic              overflow
);

    // Split fields are stored side by side; storage is never cleared, the
    // outputs are masked instead while the buffer is empty.
    logic [OP_W-1:0]   op_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    logic              push;
    logic              pop;
    logic [OP_W-1:0]   split_op;
    logic [DATA_W-1:0] split_data;

    // Handshake and field split; a pop at full frees a slot in the same cycle.
    always_comb begin
        out_valid  = (count_reg != '0);
        in_ready   = (count_reg < CW'(DEPTH)) || (out_valid && out_ready);
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        split_op   = op_low ? in_word[OP_W-1:0] : in_word[W-1:DATA_W];
        split_data = op_low ? in_word[W-1:OP_W] : in_word[DATA_W-1:0];
    end

    // One write port per entry, enabled when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PW-1:0] IDX = PW'(gi);
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == IDX)) begin
                    op_mem[gi]   <= split_op;
                    data_mem[gi] <= split_data;
                end
            end
        end
    endgenerate

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
            if (in_valid && !in_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head entry, forced to zero while nothing is held.
    always_comb begin
        out_op   = out_valid ? op_mem[rd_ptr_reg]   : '0;
        out_data = out_valid ? data_mem[rd_ptr_reg] : '0;
        count    = count_reg;
        overflow = overflow_reg;
    end

endmodule

// File: tb/tb_instr_split_buf.sv
// Directed self-checking bench for instr_split_buf with default parameters.
module tb_instr_split_buf;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_word;
    logic        op_low;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [7:0]  out_data;
    logic [1:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    instr_split_buf dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .op_low    (op_low),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] eo;
        logic [7:0] ed;

        reset = 1'b1; in_valid = 1'b0; in_word = '0; op_low = 1'b0; out_ready = 1'b0;
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_op", 32'(out_op), 0);
        chk("rst_data", 32'(out_data), 0);
        $display("reset: count=%0d valid=%0b ready=%0b", count, out_valid, in_ready);
        reset = 1'b0;

        // Opcode high, single push into empty buffer
        in_valid = 1'b1; in_word = 12'hA5C; op_low = 1'b0;
        step(); in_valid = 1'b0;
        chk("hi_valid", 32'(out_valid), 1);
        chk("hi_op", 32'(out_op), 32'hA);
        chk("hi_data", 32'(out_data), 32'h5C);
        chk("hi_count", 32'(count), 1);
        $display("push A5C op_low=0: op=%h data=%h", out_op, out_data);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("empty_count", 32'(count), 0);
        chk("empty_valid", 32'(out_valid), 0);
        chk("empty_op", 32'(out_op), 0);
        chk("empty_data", 32'(out_data), 0);

        // Opcode low; later op_low change must not touch the stored entry
        op_low = 1'b1; in_valid = 1'b1; in_word = 12'hA5C;
        step(); in_valid = 1'b0; op_low = 1'b0;
        chk("lo_op", 32'(out_op), 32'hC);
        chk("lo_data", 32'(out_data), 32'hA5);
        step();
        chk("lo_hold_op", 32'(out_op), 32'hC);
        chk("lo_hold_data", 32'(out_data), 32'hA5);
        $display("push A5C op_low=1: op=%h data=%h", out_op, out_data);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("lo_drain", 32'(count), 0);

        // Fill, then overflow attempt, then ordered drain
        op_low = 1'b0; in_valid = 1'b1; in_word = 12'h111;
        step(); in_word = 12'h222;
        step(); in_word = 12'h333;
        #1;
        chk("full_ready", 32'(in_ready), 0);
        chk("full_count", 32'(count), 2);
        step(); in_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 2);
        chk("ovf_head_op", 32'(out_op), 1);
        chk("ovf_head_data", 32'(out_data), 32'h11);
        $display("overflow attempt 333: count=%0d overflow=%0b", count, overflow);
        out_ready = 1'b1;
        step();
        chk("pop2_op", 32'(out_op), 2);
        chk("pop2_data", 32'(out_data), 32'h22);
        chk("pop2_count", 32'(count), 1);
        step();
        chk("pop_end_count", 32'(count), 0);
        chk("pop_end_valid", 32'(out_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        out_ready = 1'b0;

        // Asynchronous reset with two entries held
        in_valid = 1'b1; in_word = 12'h444;
        step(); in_word = 12'h555;
        step(); in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_op", 32'(out_op), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_ready", 32'(in_ready), 1);
        $display("async reset: count=%0d overflow=%0b", count, overflow);
        step(); reset = 1'b0;

        // Push and pop together while full
        in_valid = 1'b1; in_word = 12'h666;
        step(); in_word = 12'h777;
        step(); in_word = 12'h888; out_ready = 1'b1;
        #1;
        chk("pp_ready", 32'(in_ready), 1);
        step(); in_valid = 1'b0;
        chk("pp_count", 32'(count), 2);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_op", 32'(out_op), 7);
        chk("pp_data", 32'(out_data), 32'h77);
        step();
        chk("pp_last_op", 32'(out_op), 8);
        chk("pp_last_data", 32'(out_data), 32'h88);
        chk("pp_last_count", 32'(count), 1);
        step();
        chk("pp_empty", 32'(count), 0);
        step();
        chk("pop_empty_ignored", 32'(count), 0);

        // Continuous stream of ten words with downstream always ready
        for (int k = 0; k < 10; k++) begin
            eo = 4'(k + 3);
            ed = 8'((k * 29) + 7);
            in_valid = 1'b1; in_word = {eo, ed};
            step();
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_op", 32'(out_op), 32'(eo));
            chk("stream_data", 32'(out_data), 32'(ed));
            chk("stream_count", 32'(count), 1);
            $display("stream %0d: op=%h data=%h count=%0d", k, out_op, out_data, count);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 32'(count), 0);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_split_buf.md
INSTR_SPLIT_BUF -- requirements
Module: instr_split_buf

Interface
REQ-001 Parameter OP_W, default 4, opcode field width in bits (>=1).
REQ-002 Parameter DATA_W, default 8, data field width in bits (>=1).
REQ-003 Parameter DEPTH, default 2, buffer entries (power of two, >=2).
REQ-004 Derived W = OP_W+DATA_W; derived CW = log2(DEPTH)+1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  buffer can accept a word this cycle.
REQ-009 in_word  input  W  packed instruction word.
REQ-010 op_low  input  1  field order: 0 = opcode in [W-1:DATA_W], data in [DATA_W-1:0]; 1 = opcode in [OP_W-1:0], data in [W-1:OP_W].
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_ready  input  1  downstream accepts head entry.
REQ-013 out_op  output  OP_W  opcode field of head entry.
REQ-014 out_data  output  DATA_W  data field of head entry.
REQ-015 count  output  CW  entries currently held (0..DEPTH).
REQ-016 overflow  output  1  sticky: in_valid seen while in_ready=0.

Function
REQ-017 Push when in_valid & in_ready; pop when out_valid & out_ready.
REQ-018 Splitting per op_low is performed at push time, sampled on the push cycle; entries store split fields, so later op_low changes do not affect stored entries.
REQ-019 Buffer is FIFO; order of pops equals order of pushes.
REQ-020 in_ready = (count < DEPTH) | (out_valid & out_ready) (combinational pass-through of a same-cycle pop at full).
REQ-021 out_valid = (count != 0); out_op/out_data reflect head entry, stable while out_valid=1 and out_ready=0.
REQ-022 Latency: word pushed into empty buffer at edge N appears on out_* with out_valid=1 after edge N (one cycle); no combinational in->out path.
REQ-023 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-024 Push only: count+1; pop only: count-1; neither: hold.
REQ-025 Read/write pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 without gaps.
REQ-026 Pop when empty (out_ready=1, count=0) is ignored; no pointer or count change.
REQ-027 in_valid=1 with in_ready=0 sets overflow on that edge; word is dropped from the buffer's view (upstream holds it per handshake); overflow clears only by reset.
REQ-028 out_op/out_data when count=0 drive all zeros.
REQ-029 Field extraction is pure bit selection, no sign extension or arithmetic.

Reset
REQ-030 reset=1 forces count=0, pointers=0, overflow=0, out_valid=0, out_op=0, out_data=0, in_ready=1 asynchronously.
REQ-031 reset asserted mid-operation discards all stored entries; first push after reset deasserts behaves as into empty buffer.
REQ-032 Storage array contents need not be cleared; outputs are masked per REQ-028.

Verification
REQ-033 Defaults, op_low=0, push in_word=12'hA5C, out_ready=0 -> next cycle out_valid=1, out_op=4'hA, out_data=8'h5C, count=1.
REQ-034 Defaults, op_low=1, push 12'hA5C -> out_op=4'hC, out_data=8'hA5; then op_low=0 while held -> outputs unchanged.
REQ-035 DEPTH=2, out_ready=0, push 12'h111, 12'h222, then in_valid with 12'h333 -> count=2, in_ready=0, overflow=1; release out_ready -> pops 1/11 then 2/22 in order.
REQ-036 Full buffer, in_valid=1 and out_ready=1 same cycle -> in_ready=1, push and pop both occur, count stays 2, no overflow.
REQ-037 Stream 10 words with out_ready=1 continuously -> one word out per cycle after 1-cycle latency, pointers wrap, order preserved.
REQ-038 Assert reset with count=2 -> same-cycle count=0, out_valid=0, out_op=0, out_data=0, overflow=0, in_ready=1.
